// File: rtl/isa_pkg.sv
// isa_pkg: shared opcode/funct constants, mnemonic enum and loader FSM states.
package isa_pkg;
  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_SLT = 6'h2A;
  localparam logic [5:0] F_XOR = 6'h26;
  typedef enum logic [3:0] {
    M_ADD, M_SUB, M_AND, M_OR, M_SLT, M_XOR, M_LW, M_SW, M_BEQ, M_ADDI
  } mnem_e;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
endpackage

// File: rtl/instr_encode.sv
// instr_encode: combinational mnemonic-to-machine-word encoder with illegal flag.
module instr_encode
  import isa_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal
);
  logic [5:0] w_op;
  logic [5:0] w_funct;
  always_comb begin
    w_op = OP_RTYPE;
    w_funct = 6'd0;
    illegal = 1'b0;
    case (mnem)
      M_ADD:   w_funct = F_ADD;
      M_SUB:   w_funct = F_SUB;
      M_AND:   w_funct = F_AND;
      M_OR:    w_funct = F_OR;
      M_SLT:   w_funct = F_SLT;
      M_XOR:   w_funct = F_XOR;
      M_LW:    w_op = OP_LW;
      M_SW:    w_op = OP_SW;
      M_BEQ:   w_op = OP_BEQ;
      M_ADDI:  w_op = OP_ADDI;
      default: illegal = 1'b1;
    endcase
    word = (w_op == OP_RTYPE) ? {w_op, rs, rt, rd, 5'd0, w_funct} : {w_op, rs, rt, imm};
  end
endmodule

// File: rtl/instr_loader.sv
// instr_loader: streams mnemonic records into encoded words written sequentially to imem.
module instr_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_mnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err_illegal,
  output logic              err_overflow
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);
  state_e              r_state;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [31:0]         r_wdata;
  logic [ADDR_W:0]     r_count;
  logic                r_err_ill;
  logic                r_err_ovf;
  logic [31:0]         w_word;
  logic                w_illegal;
  logic                w_full;
  instr_encode u_enc (
    .mnem(in_mnem), .rs(in_rs), .rt(in_rt), .rd(in_rd), .imm(in_imm),
    .word(w_word), .illegal(w_illegal)
  );
  // Accepting this legal record fills the last free word.
  assign w_full = !w_illegal && r_count == (ADDR_W+1)'(DEPTH - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      r_count <= '0;
      r_err_ill <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      r_we <= 1'b0;
      if (r_state != S_RUN) begin
        if (start) begin
          r_state <= S_RUN;
          r_count <= '0;
          r_err_ill <= 1'b0;
          r_err_ovf <= 1'b0;
        end
      end else if (in_valid) begin
        if (w_illegal) begin
          r_err_ill <= 1'b1;
        end else begin
          r_we <= 1'b1;
          r_addr <= BASE_A + r_count[ADDR_W-1:0];
          r_wdata <= w_word;
          r_count <= r_count + (ADDR_W+1)'(1);
        end
        if (in_last || w_full) r_state <= S_DONE;
        if (!in_last && w_full) r_err_ovf <= 1'b1;
      end
    end
  end
  assign busy = r_state == S_RUN;
  assign done = r_state == S_DONE;
  assign in_ready = busy;
  assign imem_we = r_we;
  assign imem_addr = r_addr;
  assign imem_wdata = r_wdata;
  assign count = r_count;
  assign err_illegal = r_err_ill;
  assign err_overflow = r_err_ovf;
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed and randomized load sequences checked against a record-level model.
module tb_instr_loader;
  localparam int AW = 3;
  localparam int BASE = 5;
  localparam int DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [3:0] in_mnem = '0;
  logic [4:0] in_rs = '0, in_rt = '0, in_rd = '0;
  logic [15:0] in_imm = '0;
  logic in_ready, imem_we, busy, done, err_illegal, err_overflow;
  logic [AW-1:0] imem_addr;
  logic [31:0] imem_wdata;
  logic [AW:0] count;
  instr_loader #(.ADDR_W(AW), .BASE(BASE)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_mnem(in_mnem), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_last(in_last), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .count(count), .err_illegal(err_illegal),
    .err_overflow(err_overflow)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int fn_tbl[6] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A, 32'h26};
  int op_tbl[4] = '{35, 43, 4, 8};
  bit m_busy, m_done, m_ill, m_ovf, m_we;
  int m_cnt, m_addr;
  logic [31:0] m_data;
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [31:0] ref_word(int m, int rs, int rt, int rd, int imm);
    if (m < 6) return 32'((rs << 21) | (rt << 16) | (rd << 11) | fn_tbl[m]);
    return 32'((op_tbl[m-6] << 26) | (rs << 21) | (rt << 16) | imm);
  endfunction
  task automatic tick();
    bit legal;
    if (rst) begin
      {m_busy, m_done, m_ill, m_ovf, m_we} = '0;
      m_cnt = 0; m_addr = 0; m_data = '0;
    end else begin
      m_we = 0;
      if (!m_busy && start) begin
        m_busy = 1; m_done = 0; m_cnt = 0; m_ill = 0; m_ovf = 0;
      end else if (m_busy && in_valid) begin
        legal = in_mnem < 10;
        if (legal) begin
          m_we = 1;
          m_addr = (BASE + m_cnt) % DEPTH;
          m_data = ref_word(in_mnem, in_rs, in_rt, in_rd, in_imm);
          m_cnt++;
        end else m_ill = 1;
        if (in_last || (legal && m_cnt == DEPTH)) begin
          m_busy = 0; m_done = 1;
          if (!in_last) m_ovf = 1;
        end
      end
    end
    @(posedge clk); #1;
    chk("we", imem_we, m_we);
    chk("addr", imem_addr, m_addr);
    chk("wdata", imem_wdata, m_data);
    chk("busy", busy, m_busy);
    chk("ready", in_ready, m_busy);
    chk("done", done, m_done);
    chk("count", count, m_cnt);
    chk("err_ill", err_illegal, m_ill);
    chk("err_ovf", err_overflow, m_ovf);
  endtask
  task automatic rec(int m, int rs, int rt, int rd, int imm, bit last);
    in_valid = 1; in_mnem = 4'(m); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_imm = 16'(imm); in_last = last;
    tick();
    in_valid = 0; in_last = 0;
  endtask
  task automatic pulse_start();
    start = 1;
    tick();
    start = 0;
  endtask
  initial begin
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_idle", {busy, done, imem_we}, 0);
    pulse_start();
    rec(0, 1, 2, 3, 0, 1);
    chk("t1_data", imem_wdata, 32'h00221820);
    chk("t1_addr", imem_addr, BASE);
    chk("t1_done", done, 1);
    pulse_start();
    rec(6, 0, 4, 0, 8, 0);
    chk("lw", imem_wdata, 32'h8C040008);
    rec(7, 0, 4, 0, 12, 0);
    chk("sw", imem_wdata, 32'hAC04000C);
    rec(8, 1, 2, 0, 16'hFFFE, 0);
    chk("beq", imem_wdata, 32'h1022FFFE);
    rec(9, 0, 5, 0, 7, 1);
    chk("addi", imem_wdata, 32'h20050007);
    chk("t2_count", count, 4);
    pulse_start();
    rec(0, 1, 1, 1, 0, 0);
    rec(12, 1, 1, 1, 0, 0);
    rec(0, 2, 2, 2, 0, 1);
    chk("t3_ill", err_illegal, 1);
    chk("t3_count", count, 2);
    start = 1; in_valid = 1;
    tick();
    start = 0; in_valid = 0;
    for (int i = 0; i < DEPTH + 1; i++) rec(i % 10, i, i + 1, i + 2, i * 3, 0);
    chk("ovf_flag", err_overflow, 1);
    chk("ovf_ready", in_ready, 0);
    pulse_start();
    rec(15, 0, 0, 0, 0, 1);
    chk("ill_last_done", done, 1);
    pulse_start();
    rec(1, 3, 4, 5, 0, 0);
    rec(2, 3, 4, 5, 0, 0);
    rst = 1;
    rec(3, 3, 4, 5, 0, 0);
    rst = 0;
    chk("mid_rst", {imem_we, busy, 4'(count)}, 0);
    pulse_start();
    rec(4, 7, 8, 9, 0, 1);
    chk("reload_addr", imem_addr, BASE);
    for (int p = 0; p < 40; p++) begin
      start = 1; in_valid = $urandom_range(0, 1);
      tick();
      start = 0; in_valid = 0;
      for (int i = 0, n = $urandom_range(1, 12); i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          start = $urandom_range(0, 1);
          tick();
          start = 0;
        end
        if ($urandom_range(0, 30) == 0) rst = 1;
        rec($urandom_range(0, 15), $urandom, $urandom, $urandom, $urandom, i == n - 1);
        rst = 0;
      end
      tick();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
